// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after data bit 7.
module uart_rx_fifo #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow,
  output logic             frame_err,
  output logic             parity_err,
  input  logic             err_clr
);
  localparam int CW    = $clog2(CLK_DIV + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    DIV_FULL = CW'(CLK_DIV);
  localparam logic [CW-1:0]    DIV_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE  = (FIFO_AW + 1)'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       warm_q;
  logic             line_s, expire_s;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             frame_set_s;
  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d, ferr_q, ferr_d;
  logic             full_s, pop_s, push_ok_s, ovf_set_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d, parity_set_s, perr_q, perr_d;
`endif

  // prev_q only tracks the line once the synchronizer holds real samples, so a line
  // already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      warm_q  <= 2'b00;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
      prev_q  <= warm_q[1] ? sync2_q : 1'b0;
    end
  end

  assign line_s   = sync2_q;
  assign expire_s = (cnt_q == CNT_ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_set_s = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (prev_q && !line_s) begin
          cnt_d   = DIV_HALF;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!expire_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!line_s) begin
          cnt_d   = DIV_FULL;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!expire_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {line_s, shift_q[7:1]};
          cnt_d   = DIV_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!expire_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          par_bad_d    = (^shift_q) != line_s;
          parity_set_s = (^shift_q) != line_s;
          cnt_d        = DIV_FULL;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!expire_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (line_s) begin
`ifdef UART_RX_PARITY_EN
          push_d = !par_bad_q;
`else
          push_d = 1'b1;
`endif
          state_d = S_IDLE;
        end else begin
          frame_set_s = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (line_s) state_d = S_IDLE;
        else        state_d = S_BREAK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The assembled byte stays in shift_q for the push cycle right after the stop sample.
  always_comb begin
    full_s    = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    pop_s     = valid_q && rx_ready;
    push_ok_s = push_q && (!full_s || pop_s);
    ovf_set_s = push_q && full_s && !pop_s;
    wr_d      = push_ok_s ? wr_q + PTR_ONE : wr_q;
    rd_d      = pop_s ? rd_q + PTR_ONE : rd_q;
    count_d   = wr_d - rd_d;
    valid_d   = (wr_d != rd_d);
    if (!valid_d) begin
      data_d = data_q;
    end else if (push_ok_s && (rd_d == wr_q)) begin
      data_d = shift_q;
    end else begin
      data_d = mem_q[rd_d[FIFO_AW-1:0]];
    end
    ovf_d  = (ovf_q && !err_clr) || ovf_set_s;
    ferr_d = (ferr_q && !err_clr) || frame_set_s;
`ifdef UART_RX_PARITY_EN
    perr_d = (perr_q && !err_clr) || parity_set_s;
`endif
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_q[FIFO_AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      push_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: randomized frames against a queue-based model.
module tb_uart_rx_fifo;
  localparam int CLK_DIV = 8;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // edge index (from the start-bit drive) on which a received byte enters the FIFO
  localparam int PUSH_EDGE = 3 + CLK_DIV / 2 + (FRAME_BITS - 1) * CLK_DIV;
  localparam int STOP_MID  = (FRAME_BITS - 1) * CLK_DIV + CLK_DIV / 2;

  logic             clk = 1'b0;
  logic             rst, uart_rx, rx_ready, err_clr;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [FIFO_AW:0] fifo_count;
  logic             overflow, frame_err, parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int first_valid_cyc = -1;
  byte unsigned got_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .overflow(overflow),
    .frame_err(frame_err), .parity_err(parity_err), .err_clr(err_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor: a byte is consumed whenever valid and ready meet at an edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input int stop_low,
                            input int ready_edge);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (FRAME_BITS == 11) lv.push_back(par);
    if (stop_low > 0) begin
      for (int i = 0; i < stop_low; i++) lv.push_back(1'b0);
    end else begin
      lv.push_back(1'b1);
    end
    lv.push_back(1'b1);
    for (int c = 0; c < lv.size() * CLK_DIV; c++) begin
      uart_rx = lv[c / CLK_DIV];
      if (ready_edge >= 0) rx_ready = (c == ready_edge);
      tick();
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rx_valid, rx_data, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_fifo: valid=%b data=%h count=%0d, want 0/00/0", rx_valid, rx_data, fifo_count);
    end
    checks++;
    if ({overflow, frame_err, parity_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: %b%b%b, want 000", overflow, frame_err, parity_err);
    end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    int start, lat;
    got_q.delete(); valid_cycles = 0; first_valid_cyc = -1;
    rx_ready = 1'b1;
    start = cyc;
    send_frame(8'hA5, ^8'hA5, 0, -1);
    repeat (CLK_DIV) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %0d bytes first=%h, want 1 byte A5", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 8'h00);
    end
    checks++;
    if (valid_cycles != 1) begin
      errors++;
      $display("FAIL single_pulse: rx_valid high %0d cycles, want 1", valid_cycles);
    end
    lat = first_valid_cyc - start - STOP_MID;
    checks++;
    if (first_valid_cyc < 0 || lat < 1 || lat > CLK_DIV) begin
      errors++;
      $display("FAIL single_latency: %0d cycles after stop mid, want 1..%0d", lat, CLK_DIV);
    end
    checks++;
    if ({overflow, frame_err, parity_err} !== 3'b000) begin
      errors++;
      $display("FAIL single_flags: %b%b%b, want 000", overflow, frame_err, parity_err);
    end
  endtask

  task automatic test_overflow();
    byte unsigned sent[$], exp[$];
    byte unsigned b;
    int n;
    for (int r = 0; r < 2; r++) begin
      sent.delete(); exp.delete(); got_q.delete();
      rx_ready = 1'b0;
      n = (r == 0) ? 5 : $urandom_range(5, 7);
      for (int i = 0; i < n; i++) begin
        b = (r == 0) ? byte'(i + 1) : byte'($urandom_range(0, 255));
        sent.push_back(b);
        send_frame(b, ^b, 0, -1);
      end
      foreach (sent[i]) if (exp.size() < DEPTH) exp.push_back(sent[i]);
      checks++;
      if (fifo_count !== (FIFO_AW + 1)'(exp.size())) begin
        errors++;
        $display("FAIL ovf_count r%0d: %0d, want %0d", r, fifo_count, exp.size());
      end
      checks++;
      if (overflow !== (sent.size() > exp.size())) begin
        errors++;
        $display("FAIL ovf_flag r%0d: %b, want 1", r, overflow);
      end
      drain();
      checks++;
      if (got_q.size() != exp.size()) begin
        errors++;
        $display("FAIL ovf_len r%0d: %0d bytes, want %0d", r, got_q.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL ovf_data r%0d[%0d]: %h, want %h", r, i, got_q[i], exp[i]);
        end
      end
      clear_flags();
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL ovf_clear r%0d: %b, want 0", r, overflow);
      end
    end
  endtask

  task automatic test_full_push_pop();
    byte unsigned exp[$];
    byte unsigned b;
    got_q.delete(); rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = byte'($urandom_range(0, 255));
      exp.push_back(b);
      send_frame(b, ^b, 0, -1);
    end
    exp.push_back(8'h66);
    send_frame(8'h66, ^8'h66, 0, PUSH_EDGE);
    checks++;
    if (fifo_count !== (FIFO_AW + 1)'(DEPTH) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pp: count=%0d ovf=%b, want %0d/0", fifo_count, overflow, DEPTH);
    end
    drain();
    checks++;
    if (got_q.size() != exp.size()) begin
      errors++;
      $display("FAIL full_pp_len: %0d bytes, want %0d", got_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL full_pp_data[%0d]: %h, want %h", i, got_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_glitch();
    byte unsigned b;
    got_q.delete(); valid_cycles = 0; rx_ready = 1'b1;
    uart_rx = 1'b0;
    repeat (2) tick();
    uart_rx = 1'b1;
    repeat (3 * CLK_DIV) tick();
    checks++;
    if (valid_cycles != 0 || fifo_count !== '0 || {overflow, frame_err, parity_err} !== 3'b000) begin
      errors++;
      $display("FAIL glitch: valid_cycles=%0d count=%0d flags=%b%b%b, want 0/0/000",
               valid_cycles, fifo_count, overflow, frame_err, parity_err);
    end
    b = byte'($urandom_range(0, 255));
    send_frame(b, ^b, 0, -1);
    repeat (CLK_DIV) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== b) begin
      errors++;
      $display("FAIL glitch_next: %0d bytes, want 1 byte %h", got_q.size(), b);
    end
  endtask

  task automatic test_break();
    got_q.delete(); rx_ready = 1'b1;
    fork
      send_frame(8'h3C, ^8'h3C, 20, -1);
      begin
        repeat (PUSH_EDGE + 10) @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b1) begin
          errors++;
          $display("FAIL break_set: frame_err=%b, want 1", frame_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
      end
    join
    checks++;
    if (frame_err !== 1'b0 || got_q.size() != 0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL break_once: frame_err=%b bytes=%0d count=%0d, want 0/0/0",
               frame_err, got_q.size(), fifo_count);
    end
    send_frame(8'h7E, ^8'h7E, 0, -1);
    repeat (CLK_DIV) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h7E || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL break_next: %0d bytes ferr=%b, want 1 byte 7E ferr 0", got_q.size(), frame_err);
    end
  endtask

  task automatic test_back_to_back();
    byte unsigned sent[$];
    bit done;
    done = 1'b0;
    got_q.delete();
    fork
      begin
        byte unsigned b;
        for (int i = 0; i < 8; i++) begin
          b = byte'($urandom_range(0, 255));
          sent.push_back(b);
          send_frame(b, ^b, 0, -1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    drain();
    checks++;
    if (overflow !== 1'b0 || got_q.size() != sent.size()) begin
      errors++;
      $display("FAIL b2b_len: ovf=%b bytes=%0d, want 0/%0d", overflow, got_q.size(), sent.size());
    end
    for (int i = 0; i < sent.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== sent[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: %h, want %h", i, got_q[i], sent[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    byte unsigned b;
    got_q.delete(); rx_ready = 1'b0;
    send_frame(8'h5A, ^8'h5A, 0, -1);
    uart_rx = 1'b0;
    repeat (3 * CLK_DIV) tick();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (fifo_count !== '0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flush: count=%0d valid=%b, want 0/0", fifo_count, rx_valid);
    end
    rst = 1'b0; rx_ready = 1'b1;
    repeat (3 * CLK_DIV) tick();
    uart_rx = 1'b1;
    repeat (12 * CLK_DIV) tick();
    checks++;
    if (got_q.size() != 0 || frame_err !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL midrst_low: bytes=%0d ferr=%b count=%0d, want 0/0/0",
               got_q.size(), frame_err, fifo_count);
    end
    b = byte'($urandom_range(0, 255));
    send_frame(b, ^b, 0, -1);
    repeat (CLK_DIV) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== b) begin
      errors++;
      $display("FAIL midrst_next: %0d bytes, want 1 byte %h", got_q.size(), b);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    got_q.delete(); rx_ready = 1'b1;
    send_frame(8'h07, 1'b1, 0, -1);
    repeat (CLK_DIV) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h07 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: %0d bytes perr=%b, want 1 byte 07 perr 0", got_q.size(), parity_err);
    end
    got_q.delete();
    send_frame(8'h07, 1'b0, 0, -1);
    repeat (CLK_DIV) tick();
    checks++;
    if (got_q.size() != 0 || parity_err !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: %0d bytes perr=%b ferr=%b, want 0/1/0", got_q.size(), parity_err, frame_err);
    end
    clear_flags();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
